// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad operand entry block: key codes, entry
// states and the digit-count width helper.
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX  = 4'h9;
  localparam logic [3:0] KEY_ACCEPT_DEF = 4'hA;
  localparam logic [3:0] KEY_BACK_DEF   = 4'hB;
  localparam logic [3:0] KEY_CLEAR_DEF  = 4'hC;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  // Bits needed to count 0..digits entered digits.
  function automatic int count_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One BCD operand: shift register of DIGITS nibbles plus its digit counter.
// Exposes next-cycle values so the parent can register derived outputs.
module bcd_entry_reg
  import keypad_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int CW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                back,
  input  logic                clear,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] value_nxt,
  output logic [CW-1:0]       count_nxt,
  output logic                full,
  output logic                empty
);

  logic [4*DIGITS-1:0] value_r;
  logic [4*DIGITS-1:0] value_nxt_s;
  logic [4*DIGITS-1:0] shifted_s;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_nxt_s;

  assign full  = (count_r == CW'(DIGITS));
  assign empty = (count_r == '0);

  // Next operand value and count; clear wins over push, push over backspace.
  always_comb begin
    value_nxt_s = value_r;
    count_nxt_s = count_r;
    shifted_s   = value_r << 4;
    shifted_s[3:0] = digit;
    if (clear) begin
      value_nxt_s = '0;
      count_nxt_s = '0;
    end else if (push && !full) begin
      value_nxt_s = shifted_s;
      count_nxt_s = count_r + CW'(1'b1);
    end else if (back && !empty) begin
      value_nxt_s = value_r >> 4;
      count_nxt_s = count_r - CW'(1'b1);
    end else begin
      value_nxt_s = value_r;
      count_nxt_s = count_r;
    end
  end

  // Operand and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= '0;
      count_r <= '0;
    end else begin
      value_r <= value_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign value     = value_r;
  assign value_nxt = value_nxt_s;
  assign count_nxt = count_nxt_s;

endmodule

// File: rtl/keypad_operand_entry.sv
// Assembles two BCD operands from keypad events and hands them downstream
// with a valid/ready handshake; drives the operand under edit to the display.
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int         DIGITS     = 3,
  parameter logic [3:0] KEY_ACCEPT = KEY_ACCEPT_DEF,
  parameter logic [3:0] KEY_BACK   = KEY_BACK_DEF,
  parameter logic [3:0] KEY_CLEAR  = KEY_CLEAR_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key_code,
  input  logic                           key_pulse,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [4*DIGITS-1:0]            op_a,
  output logic [4*DIGITS-1:0]            op_b,
  output logic [4*DIGITS-1:0]            disp_bcd,
  output logic [count_width(DIGITS)-1:0] disp_count,
  output logic                           entry_sel,
  output logic                           key_ignored
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = count_width(DIGITS);

  entry_state_t  state_r, state_nxt_s;
  logic          a_push_s, a_back_s, a_clear_s;
  logic          b_push_s, b_back_s, b_clear_s;
  logic [W-1:0]  a_val_s, a_nxt_s, b_val_s, b_nxt_s;
  logic [CW-1:0] a_cnt_nxt_s, b_cnt_nxt_s;
  logic          a_full_s, a_empty_s, b_full_s, b_empty_s;
  logic          cur_full_s, cur_empty_s, is_digit_s, transfer_s, ignored_nxt_s;
  logic [W-1:0]  disp_bcd_r;
  logic [CW-1:0] disp_count_r;
  logic          entry_sel_r, out_valid_r, key_ignored_r;

  bcd_entry_reg #(.DIGITS(DIGITS), .CW(CW)) u_reg_a (
    .clk(clk), .rst(rst), .push(a_push_s), .back(a_back_s), .clear(a_clear_s),
    .digit(key_code), .value(a_val_s), .value_nxt(a_nxt_s), .count_nxt(a_cnt_nxt_s),
    .full(a_full_s), .empty(a_empty_s)
  );

  bcd_entry_reg #(.DIGITS(DIGITS), .CW(CW)) u_reg_b (
    .clk(clk), .rst(rst), .push(b_push_s), .back(b_back_s), .clear(b_clear_s),
    .digit(key_code), .value(b_val_s), .value_nxt(b_nxt_s), .count_nxt(b_cnt_nxt_s),
    .full(b_full_s), .empty(b_empty_s)
  );

  // Key decode and entry FSM next state; a transfer overrides any key in the same cycle.
  always_comb begin
    state_nxt_s   = state_r;
    a_push_s      = 1'b0;
    a_back_s      = 1'b0;
    a_clear_s     = 1'b0;
    b_push_s      = 1'b0;
    b_back_s      = 1'b0;
    b_clear_s     = 1'b0;
    ignored_nxt_s = 1'b0;
    transfer_s    = (state_r == DONE) && out_ready;
    is_digit_s    = (key_code <= KEY_DIGIT_MAX);
    cur_full_s    = (state_r == ENTER_B) ? b_full_s : a_full_s;
    cur_empty_s   = (state_r == ENTER_B) ? b_empty_s : a_empty_s;
    if (transfer_s) begin
      state_nxt_s   = ENTER_A;
      a_clear_s     = 1'b1;
      b_clear_s     = 1'b1;
      ignored_nxt_s = key_pulse && (key_code != KEY_CLEAR);
    end else if (!key_pulse) begin
      state_nxt_s = state_r;
    end else if (key_code == KEY_CLEAR) begin
      state_nxt_s = ENTER_A;
      a_clear_s   = 1'b1;
      b_clear_s   = 1'b1;
    end else begin
      case (state_r)
        ENTER_A, ENTER_B: begin
          if (key_code == KEY_ACCEPT) begin
            if (cur_empty_s) ignored_nxt_s = 1'b1;
            else state_nxt_s = (state_r == ENTER_A) ? ENTER_B : DONE;
          end else if (key_code == KEY_BACK) begin
            if (cur_empty_s) begin
              ignored_nxt_s = 1'b1;
            end else begin
              a_back_s = (state_r == ENTER_A);
              b_back_s = (state_r == ENTER_B);
            end
          end else if (is_digit_s) begin
            if (cur_full_s) begin
              ignored_nxt_s = 1'b1;
            end else begin
              a_push_s = (state_r == ENTER_A);
              b_push_s = (state_r == ENTER_B);
            end
          end else begin
            ignored_nxt_s = 1'b1;
          end
        end
        DONE: ignored_nxt_s = 1'b1;
        default: begin
          state_nxt_s = ENTER_A;
          a_clear_s   = 1'b1;
          b_clear_s   = 1'b1;
        end
      endcase
    end
  end

  // State and registered status/display outputs, derived from next-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ENTER_A;
      disp_bcd_r    <= '0;
      disp_count_r  <= '0;
      entry_sel_r   <= 1'b0;
      out_valid_r   <= 1'b0;
      key_ignored_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      disp_bcd_r    <= (state_nxt_s == ENTER_A) ? a_nxt_s : b_nxt_s;
      disp_count_r  <= (state_nxt_s == ENTER_A) ? a_cnt_nxt_s : b_cnt_nxt_s;
      entry_sel_r   <= (state_nxt_s != ENTER_A);
      out_valid_r   <= (state_nxt_s == DONE);
      key_ignored_r <= ignored_nxt_s;
    end
  end

  assign op_a        = a_val_s;
  assign op_b        = b_val_s;
  assign disp_bcd    = disp_bcd_r;
  assign disp_count  = disp_count_r;
  assign entry_sel   = entry_sel_r;
  assign out_valid   = out_valid_r;
  assign key_ignored = key_ignored_r;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench for keypad_operand_entry: each step pushes the expected
// output snapshot, drives one cycle, then pops and compares.
module tb_keypad_operand_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = 4'h0;
  logic        key_pulse = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] op_a, op_b, disp_bcd;
  logic [1:0]  disp_count;
  logic        entry_sel, key_ignored;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] d;
    logic [1:0]  c;
    logic        s;
    logic        v;
    logic        i;
  } snap_t;

  typedef struct packed {
    logic [3:0] code;
    logic       pulse;
    logic       ready;
    logic       rst_v;
    snap_t      e;
  } step_t;

  snap_t sb[$];

  keypad_operand_entry dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_pulse(key_pulse),
    .out_ready(out_ready), .out_valid(out_valid), .op_a(op_a), .op_b(op_b),
    .disp_bcd(disp_bcd), .disp_count(disp_count), .entry_sel(entry_sel),
    .key_ignored(key_ignored)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(logic [11:0] a, logic [11:0] b, logic [11:0] d,
                               logic [1:0] c, logic s, logic v, logic i);
    snap_t r;
    r = '{a: a, b: b, d: d, c: c, s: s, v: v, i: i};
    return r;
  endfunction

  function automatic step_t sp(logic [3:0] code, logic pulse, logic ready, logic rv, snap_t e);
    step_t r;
    r = '{code: code, pulse: pulse, ready: ready, rst_v: rv, e: e};
    return r;
  endfunction

  function automatic snap_t sample();
    return mk(op_a, op_b, disp_bcd, disp_count, entry_sel, out_valid, key_ignored);
  endfunction

  // One clock of stimulus; outputs are then settled 1 time unit after the edge.
  task automatic drive(logic [3:0] code, logic pulse, logic ready, logic rv);
    @(negedge clk);
    key_code  = code;
    key_pulse = pulse;
    out_ready = ready;
    rst       = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    snap_t e, o;
    s.push_back(sp(4'h5, 1'b1, 1'b0, 1'b1, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h0, 1'b0, 1'b0, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  task automatic test_basic_entry();
    step_t s[$];
    snap_t e, o;
    snap_t done_e;
    done_e = mk(12'h123, 12'h045, 12'h045, 2'd2, 1'b1, 1'b1, 1'b0);
    s.push_back(sp(4'h1, 1'b1, 1'b0, 1'b0, mk(12'h001, 12'h000, 12'h001, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h2, 1'b1, 1'b0, 1'b0, mk(12'h012, 12'h000, 12'h012, 2'd2, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h3, 1'b1, 1'b0, 1'b0, mk(12'h123, 12'h000, 12'h123, 2'd3, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h123, 12'h000, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h4, 1'b1, 1'b0, 1'b0, mk(12'h123, 12'h004, 12'h004, 2'd1, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h5, 1'b1, 1'b0, 1'b0, mk(12'h123, 12'h045, 12'h045, 2'd2, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, done_e));
    for (int n = 0; n < 20; n++) s.push_back(sp(4'h7, 1'b0, 1'b0, 1'b0, done_e));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_entry step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  task automatic test_handshake();
    step_t s[$];
    snap_t e, o;
    s.push_back(sp(4'h4, 1'b1, 1'b0, 1'b0, mk(12'h123, 12'h045, 12'h045, 2'd2, 1'b1, 1'b1, 1'b1)));
    s.push_back(sp(4'h0, 1'b0, 1'b1, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h0, 1'b0, 1'b0, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL handshake step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  task automatic test_overflow();
    step_t s[$];
    snap_t e, o;
    s.push_back(sp(4'h9, 1'b1, 1'b0, 1'b0, mk(12'h009, 12'h000, 12'h009, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h8, 1'b1, 1'b0, 1'b0, mk(12'h098, 12'h000, 12'h098, 2'd2, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h7, 1'b1, 1'b0, 1'b0, mk(12'h987, 12'h000, 12'h987, 2'd3, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h6, 1'b1, 1'b0, 1'b0, mk(12'h987, 12'h000, 12'h987, 2'd3, 1'b0, 1'b0, 1'b1)));
    s.push_back(sp(4'h0, 1'b0, 1'b0, 1'b0, mk(12'h987, 12'h000, 12'h987, 2'd3, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hC, 1'b1, 1'b0, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overflow step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  // out_ready is held high here: it must have no effect outside DONE.
  task automatic test_backspace();
    step_t s[$];
    snap_t e, o;
    s.push_back(sp(4'h5, 1'b1, 1'b1, 1'b0, mk(12'h005, 12'h000, 12'h005, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h7, 1'b1, 1'b1, 1'b0, mk(12'h057, 12'h000, 12'h057, 2'd2, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hB, 1'b1, 1'b1, 1'b0, mk(12'h005, 12'h000, 12'h005, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hB, 1'b1, 1'b1, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hB, 1'b1, 1'b1, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1)));
    s.push_back(sp(4'hA, 1'b1, 1'b1, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1)));
    s.push_back(sp(4'h0, 1'b0, 1'b0, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL backspace step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  task automatic test_clear_in_b();
    step_t s[$];
    snap_t e, o;
    s.push_back(sp(4'h7, 1'b1, 1'b0, 1'b0, mk(12'h007, 12'h000, 12'h007, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h007, 12'h000, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h1, 1'b1, 1'b0, 1'b0, mk(12'h007, 12'h001, 12'h001, 2'd1, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h2, 1'b1, 1'b0, 1'b0, mk(12'h007, 12'h012, 12'h012, 2'd2, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'hD, 1'b1, 1'b0, 1'b0, mk(12'h007, 12'h012, 12'h012, 2'd2, 1'b1, 1'b0, 1'b1)));
    s.push_back(sp(4'hF, 1'b1, 1'b0, 1'b0, mk(12'h007, 12'h012, 12'h012, 2'd2, 1'b1, 1'b0, 1'b1)));
    s.push_back(sp(4'hC, 1'b1, 1'b0, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clear_in_b step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  task automatic test_rst_in_done();
    step_t s[$];
    snap_t e, o;
    s.push_back(sp(4'h1, 1'b1, 1'b0, 1'b0, mk(12'h001, 12'h000, 12'h001, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h001, 12'h000, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h2, 1'b1, 1'b0, 1'b0, mk(12'h001, 12'h002, 12'h002, 2'd1, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h001, 12'h002, 12'h002, 2'd1, 1'b1, 1'b1, 1'b0)));
    s.push_back(sp(4'h3, 1'b1, 1'b0, 1'b1, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h0, 1'b0, 1'b0, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0)));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_in_done step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  // Keys on consecutive cycles, then transfers coinciding with a digit and with CLEAR.
  task automatic test_back_to_back();
    step_t s[$];
    snap_t e, o;
    snap_t z;
    z = mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    s.push_back(sp(4'h1, 1'b1, 1'b0, 1'b0, mk(12'h001, 12'h000, 12'h001, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'h2, 1'b1, 1'b0, 1'b0, mk(12'h012, 12'h000, 12'h012, 2'd2, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h012, 12'h000, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h3, 1'b1, 1'b0, 1'b0, mk(12'h012, 12'h003, 12'h003, 2'd1, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h012, 12'h003, 12'h003, 2'd1, 1'b1, 1'b1, 1'b0)));
    s.push_back(sp(4'h5, 1'b1, 1'b1, 1'b0, mk(12'h000, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1)));
    s.push_back(sp(4'h8, 1'b1, 1'b0, 1'b0, mk(12'h008, 12'h000, 12'h008, 2'd1, 1'b0, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h008, 12'h000, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'h6, 1'b1, 1'b0, 1'b0, mk(12'h008, 12'h006, 12'h006, 2'd1, 1'b1, 1'b0, 1'b0)));
    s.push_back(sp(4'hA, 1'b1, 1'b0, 1'b0, mk(12'h008, 12'h006, 12'h006, 2'd1, 1'b1, 1'b1, 1'b0)));
    s.push_back(sp(4'hC, 1'b1, 1'b1, 1'b0, z));
    s.push_back(sp(4'h0, 1'b0, 1'b0, 1'b0, z));
    foreach (s[k]) begin
      sb.push_back(s[k].e);
      drive(s[k].code, s[k].pulse, s[k].ready, s[k].rst_v);
      e = sb.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h required %h (a,b,disp,cnt,sel,valid,ign)", k, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_handshake();
    test_overflow();
    test_backspace();
    test_clear_in_b();
    test_rst_in_done();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
